// File: rtl/rf_wb_arbiter.sv
// Two-source writeback buffer for the register file's single write port.
// Per-source FIFOs drain one entry per cycle (round-robin or fixed priority); r0 writes are dropped.
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s0_valid_i,
  output logic        s0_ready_o,
  input  logic [4:0]  s0_addr_i,
  input  logic [31:0] s0_data_i,
  input  logic        s1_valid_i,
  output logic        s1_ready_o,
  input  logic [4:0]  s1_addr_i,
  input  logic [31:0] s1_data_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        zero_drop_o,
  output logic [31:0] pending_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]    addr_mem_q [2][DEPTH];
  logic [31:0]   data_mem_q [2][DEPTH];
  logic [AW-1:0] wptr_q [2];
  logic [AW-1:0] wptr_d [2];
  logic [AW-1:0] rptr_q [2];
  logic [AW-1:0] rptr_d [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];
  logic          rr_q, rr_d;

  logic [1:0]    in_valid, push, pop, nonempty;
  logic [4:0]    in_addr [2];
  logic [31:0]   in_data [2];
  logic          gnt_vld, gnt_idx;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  assign in_valid   = {s1_valid_i, s0_valid_i};
  assign in_addr[0] = s0_addr_i;
  assign in_addr[1] = s1_addr_i;
  assign in_data[0] = s0_data_i;
  assign in_data[1] = s1_data_i;

  // Ready depends only on registered count: a same-cycle pop never frees a slot.
  assign s0_ready_o = (cnt_q[0] != FULL_CNT);
  assign s1_ready_o = (cnt_q[1] != FULL_CNT);

  always_comb begin
    push     = '0;
    nonempty = '0;
    for (int k = 0; k < 2; k++) begin
      nonempty[k] = (cnt_q[k] != '0);
      push[k]     = in_valid[k] && (cnt_q[k] != FULL_CNT);
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (nonempty[0] && nonempty[1]) begin
      gnt_vld = 1'b1;
      gnt_idx = FIXED_PRIO ? 1'b0 : rr_q;
    end else if (nonempty[0]) begin
      gnt_vld = 1'b1;
    end else if (nonempty[1]) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b1;
    end
  end

  assign pop[0]    = gnt_vld && !gnt_idx;
  assign pop[1]    = gnt_vld && gnt_idx;
  assign head_addr = addr_mem_q[gnt_idx][rptr_q[gnt_idx]];
  assign head_data = data_mem_q[gnt_idx][rptr_q[gnt_idx]];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wptr_d[k] = push[k] ? wptr_q[k] + 1'b1 : wptr_q[k];
      rptr_d[k] = pop[k]  ? rptr_q[k] + 1'b1 : rptr_q[k];
      cnt_d[k]  = cnt_q[k];
      if (push[k] && !pop[k]) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end else if (!push[k] && pop[k]) begin
        cnt_d[k] = cnt_q[k] - 1'b1;
      end
    end
    rr_d = gnt_vld ? ~gnt_idx : rr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 2; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      rr_q <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      rr_q <= rr_d;
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the counts.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        addr_mem_q[k][wptr_q[k]] <= in_addr[k];
        data_mem_q[k][wptr_q[k]] <= in_data[k];
      end
    end
  end

  always_comb begin
    rf_we_o     = 1'b0;
    rf_waddr_o  = '0;
    rf_wdata_o  = '0;
    zero_drop_o = 1'b0;
    if (gnt_vld) begin
      if (head_addr != '0) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = head_addr;
        rf_wdata_o = head_data;
      end else begin
        zero_drop_o = 1'b1;
      end
    end
  end

  always_comb begin
    pending_o = '0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (CW'(j) < cnt_q[k]) begin
          pending_o[addr_mem_q[k][AW'(rptr_q[k] + AW'(j))]] = 1'b1;
        end
      end
    end
    pending_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized bench: a round-robin DEPTH=2 instance and a fixed-priority DEPTH=4 instance
// share the same stimulus and are each checked against a queue-based reference model.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s0_valid, s1_valid;
  logic [4:0]  s0_addr, s1_addr;
  logic [31:0] s0_data, s1_data;

  logic        s0_ready [2];
  logic        s1_ready [2];
  logic        rf_we [2];
  logic        zero_drop [2];
  logic [4:0]  rf_waddr [2];
  logic [31:0] rf_wdata [2];
  logic [31:0] pending [2];

  rf_wb_arbiter #(.DEPTH(2), .FIXED_PRIO(1'b0)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .s0_valid_i(s0_valid), .s0_ready_o(s0_ready[0]), .s0_addr_i(s0_addr), .s0_data_i(s0_data),
    .s1_valid_i(s1_valid), .s1_ready_o(s1_ready[0]), .s1_addr_i(s1_addr), .s1_data_i(s1_data),
    .rf_we_o(rf_we[0]), .rf_waddr_o(rf_waddr[0]), .rf_wdata_o(rf_wdata[0]),
    .zero_drop_o(zero_drop[0]), .pending_o(pending[0])
  );

  rf_wb_arbiter #(.DEPTH(4), .FIXED_PRIO(1'b1)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .s0_valid_i(s0_valid), .s0_ready_o(s0_ready[1]), .s0_addr_i(s0_addr), .s0_data_i(s0_data),
    .s1_valid_i(s1_valid), .s1_ready_o(s1_ready[1]), .s1_addr_i(s1_addr), .s1_data_i(s1_data),
    .rf_we_o(rf_we[1]), .rf_waddr_o(rf_waddr[1]), .rf_wdata_o(rf_wdata[1]),
    .zero_drop_o(zero_drop[1]), .pending_o(pending[1])
  );

  // Reference state: mq[2*inst + src] holds {addr, data} in arrival order.
  typedef logic [36:0] ent_t;
  ent_t mq [4][$];
  logic mrr [2];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int dep(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int mgrant(input int i);
    bit a, b;
    a = mq[2*i].size() > 0;
    b = mq[2*i+1].size() > 0;
    if (a && b) return (i == 1) ? 0 : int'(mrr[i]);
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic check_inst(input int i);
    int          g;
    ent_t        h;
    logic [31:0] p;
    string       t;
    t = (i == 0) ? "rr" : "fp";
    g = mgrant(i);
    p = '0;
    for (int s = 0; s < 2; s++)
      for (int j = 0; j < mq[2*i+s].size(); j++) p[mq[2*i+s][j][36:32]] = 1'b1;
    p[0] = 1'b0;
    chk({t, ".s0_ready"}, 32'(s0_ready[i]), 32'(mq[2*i].size() < dep(i)));
    chk({t, ".s1_ready"}, 32'(s1_ready[i]), 32'(mq[2*i+1].size() < dep(i)));
    chk({t, ".pending"}, pending[i], p);
    if (g < 0) begin
      chk({t, ".we_idle"}, 32'(rf_we[i]), 32'd0);
      chk({t, ".drop_idle"}, 32'(zero_drop[i]), 32'd0);
      chk({t, ".waddr_idle"}, 32'(rf_waddr[i]), 32'd0);
      chk({t, ".wdata_idle"}, rf_wdata[i], 32'd0);
    end else begin
      h = mq[2*i+g][0];
      chk({t, ".we"}, 32'(rf_we[i]), 32'(h[36:32] != 5'd0));
      chk({t, ".zero_drop"}, 32'(zero_drop[i]), 32'(h[36:32] == 5'd0));
      if (h[36:32] != 5'd0) begin
        chk({t, ".waddr"}, 32'(rf_waddr[i]), 32'(h[36:32]));
        chk({t, ".wdata"}, rf_wdata[i], h[31:0]);
      end
    end
  endtask

  // Applies one clock edge to the model using the inputs present before the edge.
  task automatic step_inst(input int i);
    int g;
    bit p0, p1;
    g  = mgrant(i);
    p0 = s0_valid && (mq[2*i].size() < dep(i));
    p1 = s1_valid && (mq[2*i+1].size() < dep(i));
    if (g >= 0) begin
      void'(mq[2*i+g].pop_front());
      mrr[i] = (g == 0);
    end
    if (p0) mq[2*i].push_back({s0_addr, s0_data});
    if (p1) mq[2*i+1].push_back({s1_addr, s1_data});
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mq[k].delete();
    mrr[0] = 1'b0;
    mrr[1] = 1'b0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return 5'd0;
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(1, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int  pct;
    bit  in_rst;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_addr = '0; s1_addr = '0; s0_data = '0; s1_data = '0;
    model_reset();
    #1;
    check_inst(0);
    check_inst(1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (in_rst) begin
        rst = 1'b0;
        in_rst = 1'b0;
      end
      check_inst(0);
      check_inst(1);

      if (cyc == 0) begin
        s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
        s1_valid = 1'b0;
      end else if (cyc < 4) begin
        s0_valid = 1'b0; s1_valid = 1'b0;
      end else begin
        pct = ((cyc / 150) % 2 == 0) ? 90 : 35;
        s0_valid = ($urandom_range(0, 99) < pct);
        s1_valid = ($urandom_range(0, 99) < pct);
        s0_addr  = rand_addr();
        s1_addr  = rand_addr();
        s0_data  = $urandom;
        s1_data  = $urandom;
      end

      if (cyc > 20 && (cyc % 500) == 140) begin
        rst = 1'b1;
        in_rst = 1'b1;
        #1;
        model_reset();
        check_inst(0);
        check_inst(1);
      end

      @(posedge clk);
      if (!in_rst) begin
        step_inst(0);
        step_inst(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and buffer in front of the 32x32 register file. Two writeback sources share the register file's single write port: source 0 is the ALU/branch writeback and source 1 is the load/multiply writeback. Each source enqueues into its own small FIFO. The block drains one entry per cycle into the register file using round-robin or fixed priority. It also filters writes to r0 and publishes a pending-write mask for the hazard unit.

## Interface
Parameters:
- DEPTH, 2, entries per source FIFO; power of two, ≥2
- FIXED_PRIO, 0, 0 = round-robin; 1 = source 0 always wins

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- s0_valid  in  1  source 0 write request
- s0_ready  out  1  source 0 FIFO can accept
- s0_addr  in  5  source 0 destination register
- s0_data  in  32  source 0 write data
- s1_valid, s1_ready, s1_addr, s1_data  same as above, for source 1
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- zero_drop  out  1  one-cycle pulse: an r0-targeted entry was retired without a write
- pending  out  32  bit i = 1 when any FIFO entry targets register i (i≠0); bit 0 is always 0

## Operation
- Enqueue:
  - Source k transfers on a cycle where sk_valid && sk_ready. {addr, data} is written at the FIFO tail.
  - sk_ready = !full_k. A pop in the same cycle does not raise ready (no pass-through).
  - Data may change while valid && !ready; nothing is captured.
- Arbitration (combinational from registered state):
  - Candidates are the non-empty FIFO heads.
  - One valid head: that source is granted.
  - Both valid with FIXED_PRIO=1: source 0 is granted.
  - Both valid with FIXED_PRIO=0: source rr_ptr is granted.
  - After any grant, rr_ptr <= ~granted_index. rr_ptr is unused when FIXED_PRIO=1.
- Retire:
  - The granted head is popped at the posedge.
  - If head addr ≠ 0: rf_we=1, rf_waddr=head addr, rf_wdata=head data.
  - If head addr = 0: rf_we=0, zero_drop=1.
  - No grant: rf_we=0, zero_drop=0; rf_waddr and rf_wdata drive 0.
- Ordering:
  - FIFO order is preserved within each source.
  - No ordering is guaranteed between sources. The hazard unit must not issue two in-flight writes to the same register from different sources; it uses `pending` for this.
- Pointers and counts:
  - Each FIFO has log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
  - Each FIFO has a (log2(DEPTH)+1)-bit count with range 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- pending:
  - OR over all occupied entries of both FIFOs of one-hot(addr), with bit 0 forced to 0.
  - Updated from registered state, so it reflects entries enqueued at the previous edge.
  - The entry being retired this cycle is still counted.

## Timing
- Reset (async, immediate):
  - Both FIFOs are emptied and all in-flight entries are discarded.
  - rr_ptr=0.
  - Outputs during reset: s0_ready=s1_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, zero_drop=0, pending=0.
  - Storage contents need not be cleared.
- Latency:
  - An entry accepted on the edge ending cycle N has rf_we=1 in cycle N+1 at the earliest. The register file commits it on the edge ending N+1.
  - Throughput is one retire per cycle total across both sources.
- Same-cycle events:
  - Push and pop on the same FIFO: count unchanged; both pointers advance.
  - Push to an empty FIFO: the entry is not eligible for grant until the next cycle.
- Starvation:
  - FIXED_PRIO=0: with both sources continuously backlogged, grants alternate 0,1,0,1…; worst-case wait is DEPTH×2 cycles.
  - FIXED_PRIO=1: source 1 can starve; this is acceptable by design.
- Reset deasserted mid-stream: the first grant can occur in the cycle after the first accepted push.

## Test plan
- Single write: s0 pushes (addr=5, data=0xDEADBEEF) in cycle 1 → cycle 2 shows rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, and pending[5]=1; cycle 3 shows pending=0.
- Round-robin: fill both FIFOs with DEPTH=2 (s0: r1,r2; s1: r3,r4), FIXED_PRIO=0, rr_ptr=0 → retire order r1,r3,r2,r4 on 4 consecutive cycles; both readies go high again after their first pop.
- Fixed priority: FIXED_PRIO=1, s0 pushes every cycle and s1 holds one entry (r7) → r7 is never retired while s0 has entries; r7 retires one cycle after s0 drains.
- r0 filter: s1 pushes (addr=0, data=0x1234) → one cycle with rf_we=0 and zero_drop=1; pending stays 0; the FIFO empties.
- Full/back-pressure: s0 pushes 3 entries back-to-back with DEPTH=2 and s1 also busy → s0_ready=0 on the 3rd attempt; the 3rd entry is accepted only on the cycle after the count drops, with no duplicate and no loss.
- Reset mid-operation: both FIFOs full, assert rst between edges → rf_we, zero_drop and pending read 0 immediately; after release no stale entries retire and rr_ptr=0.
